fifo_32x32_ctrl: RTL and testbench

FIFO_32X32_CTRL -- requirements
Module: fifo_32x32_ctrl

---
 rtl/fifo_32x32_ctrl_pkg.sv | 20 ++
 rtl/fifo_32x32_ctrl_sram.sv | 24 ++
 rtl/fifo_32x32_ctrl.sv | 88 ++++++++
 tb/tb_fifo_32x32_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_32x32_ctrl_pkg.sv
// Shared geometry constants and helpers for the 32x32 first-word-fall-through FIFO.
package fifo_32x32_ctrl_pkg;

    localparam int FIFO_DEPTH = 32;
    localparam int FIFO_WIDTH = 32;
    localparam int PTR_W      = 5;
    localparam int CNT_W      = 6;

    typedef logic [PTR_W-1:0]      ptr_t;
    typedef logic [CNT_W-1:0]      count_t;
    typedef logic [FIFO_WIDTH-1:0] word_t;

    localparam count_t FULL_COUNT = count_t'(FIFO_DEPTH);

    // Larger of two levels; used for the high-water mark.
    function automatic count_t max_level(input count_t a, input count_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fifo_32x32_ctrl_sram.sv
// 32x32 dual-port storage: synchronous write, asynchronous read, never reset.
module sram32x32DpAr
    import fifo_32x32_ctrl_pkg::*;
(
    input  logic  writeClock,
    input  logic  writeEnable,
    input  ptr_t  writeAddress,
    input  word_t writeData,
    input  ptr_t  readAddress,
    output word_t dataReadPort
);

    word_t mem [FIFO_DEPTH];

    // Write port: one word per rising edge when enabled.
    always_ff @(posedge writeClock) begin
        if (writeEnable) begin
            mem[writeAddress] <= writeData;
        end
    end

    assign dataReadPort = mem[readAddress];

endmodule

// File: rtl/fifo_32x32_ctrl.sv
// 32-deep, 32-bit first-word-fall-through FIFO controller with fill level,
// almost-full flag, high-water mark and synchronous flush.
module fifo_32x32_ctrl
    import fifo_32x32_ctrl_pkg::*;
#(
    parameter int ALMOST_FULL_LEVEL = 28
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         pushValid,
    input  logic [31:0]  pushData,
    output logic         pushReady,
    output logic         popValid,
    input  logic         popReady,
    output logic [31:0]  popData,
    output logic [5:0]   fillLevel,
    output logic         almostFull,
    output logic [5:0]   peakLevel
);

    ptr_t   writePtr;
    ptr_t   readPtr;
    count_t fillCount;
    count_t peakCount;
    count_t nextFill;
    word_t  ramData;
    logic   push;
    logic   pop;

    // Handshakes come straight from registered state; clear suppresses both
    // so a flushed cycle never writes storage or moves a pointer.
    assign pushReady = (fillCount != FULL_COUNT);
    assign popValid  = (fillCount != '0);
    assign push      = pushValid && pushReady && !clear;
    assign pop       = popValid && popReady && !clear;

    // Storage only ever presents words behind readPtr once popValid is set,
    // so unwritten locations are masked by the popValid gate below.
    sram32x32DpAr u_sram (
        .writeClock   (clock),
        .writeEnable  (push),
        .writeAddress (writePtr),
        .writeData    (pushData),
        .readAddress  (readPtr),
        .dataReadPort (ramData)
    );

    // Next occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        nextFill = fillCount;
        if (push && !pop) begin
            nextFill = fillCount + count_t'(1);
        end else if (pop && !push) begin
            nextFill = fillCount - count_t'(1);
        end
    end

    // Pointer, occupancy and high-water state; pointers wrap naturally at 5 bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            writePtr  <= '0;
            readPtr   <= '0;
            fillCount <= '0;
            peakCount <= '0;
        end else if (clear) begin
            writePtr  <= '0;
            readPtr   <= '0;
            fillCount <= '0;
            peakCount <= '0;
        end else begin
            if (push) begin
                writePtr <= writePtr + ptr_t'(1);
            end
            if (pop) begin
                readPtr <= readPtr + ptr_t'(1);
            end
            fillCount <= nextFill;
            peakCount <= max_level(peakCount, nextFill);
        end
    end

    assign popData    = popValid ? ramData : '0;
    assign fillLevel  = fillCount;
    assign peakLevel  = peakCount;
    assign almostFull = (fillCount >= count_t'(ALMOST_FULL_LEVEL));

endmodule

// File: tb/tb_fifo_32x32_ctrl.sv
// Scoreboard bench for fifo_32x32_ctrl: a queue-based reference model runs in
// the driver, expectations are queued, and a negedge monitor compares them.
module tb_fifo_32x32_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        pushValid = 1'b0;
    logic [31:0] pushData = '0;
    logic        pushReady;
    logic        popValid;
    logic        popReady = 1'b0;
    logic [31:0] popData;
    logic [5:0]  fillLevel;
    logic        almostFull;
    logic [5:0]  peakLevel;

    fifo_32x32_ctrl #(.ALMOST_FULL_LEVEL(28)) dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .pushValid  (pushValid),
        .pushData   (pushData),
        .pushReady  (pushReady),
        .popValid   (popValid),
        .popReady   (popReady),
        .popData    (popData),
        .fillLevel  (fillLevel),
        .almostFull (almostFull),
        .peakLevel  (peakLevel)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          fill;
        int          peak;
        logic [31:0] head;
        string       tag;
    } exp_t;

    // Reference model state.
    logic [31:0] mq[$];
    int          mpeak = 0;
    // Scoreboard queues.
    exp_t        lvlQ[$];
    logic [31:0] popQ[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // One clock of stimulus; model decides what the FIFO must do this cycle.
    task automatic step(input logic pv, input logic [31:0] pd, input logic pr,
                        input logic clr, input string tag);
        exp_t e;
        bit   doPush;
        bit   doPop;
        @(posedge clock);
        #1;
        pushValid = pv;
        pushData  = pd;
        popReady  = pr;
        clear     = clr;
        e.fill = mq.size();
        e.peak = mpeak;
        e.head = (mq.size() != 0) ? mq[0] : 32'h0;
        e.tag  = tag;
        lvlQ.push_back(e);
        doPush = pv && (mq.size() < 32) && !clr;
        doPop  = pr && (mq.size() > 0) && !clr;
        if (doPop) popQ.push_back(mq.pop_front());
        if (doPush) mq.push_back(pd);
        if (clr) begin
            mq.delete();
            mpeak = 0;
        end else if (mq.size() > mpeak) begin
            mpeak = mq.size();
        end
    endtask

    task automatic idle_inputs();
        pushValid = 1'b0;
        popReady  = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".fillLevel"},  32'(fillLevel),  32'd0);
        check({tag, ".pushReady"},  32'(pushReady),  32'd1);
        check({tag, ".popValid"},   32'(popValid),   32'd0);
        check({tag, ".popData"},    popData,         32'h0);
        check({tag, ".almostFull"}, 32'(almostFull), 32'd0);
        check({tag, ".peakLevel"},  32'(peakLevel),  32'd0);
    endtask

    // Monitor: compares registered-state outputs and popped words mid-cycle.
    always @(negedge clock) begin
        exp_t e;
        if (lvlQ.size() != 0) begin
            e = lvlQ.pop_front();
            check({e.tag, ".fillLevel"},  32'(fillLevel),  32'(e.fill));
            check({e.tag, ".pushReady"},  32'(pushReady),  32'(e.fill != 32));
            check({e.tag, ".popValid"},   32'(popValid),   32'(e.fill != 0));
            check({e.tag, ".almostFull"}, 32'(almostFull), 32'(e.fill >= 28));
            check({e.tag, ".peakLevel"},  32'(peakLevel),  32'(e.peak));
            check({e.tag, ".popData"},    popData,         e.head);
            if (popValid && popReady && !clear) begin
                if (popQ.size() == 0) begin
                    check({e.tag, ".unexpectedPop"}, popData, 32'hDEAD_BEEF);
                end else begin
                    check({e.tag, ".popWord"}, popData, popQ.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset held from time 0: outputs must already be at reset values.
        #3;
        check_reset_outputs("initReset");
        @(posedge clock);
        #1 reset = 1'b0;

        // Fill to full, 33rd push refused.
        for (int i = 0; i < 33; i++) step(1'b1, 32'h100 + i, 1'b0, 1'b0, "fill");
        step(1'b0, 32'h0, 1'b0, 1'b0, "full");
        // Drain in order, then empty outputs.
        for (int i = 0; i < 32; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "drain");
        step(1'b0, 32'h0, 1'b1, 1'b0, "drained");

        // Wrap: hold level 1 with push/pop pairs.
        step(1'b1, 32'hA000, 1'b0, 1'b0, "wrapPrime");
        for (int i = 1; i <= 40; i++) step(1'b1, 32'hA000 + i, 1'b1, 1'b0, "wrap");
        step(1'b0, 32'h0, 1'b1, 1'b0, "wrapDrain");
        step(1'b0, 32'h0, 1'b0, 1'b0, "wrapEmpty");

        // Empty + push + pop: only the push happens.
        step(1'b1, 32'hB000, 1'b1, 1'b0, "emptyBoth");
        for (int i = 1; i < 32; i++) step(1'b1, 32'hB000 + i, 1'b0, 1'b0, "refill");
        // Full + push + pop: only the pop happens.
        step(1'b1, 32'hBFFF, 1'b1, 1'b0, "fullBoth");
        step(1'b0, 32'h0, 1'b0, 1'b0, "after31");

        // Clear and peak.
        step(1'b0, 32'h0, 1'b0, 1'b1, "preClear");
        for (int i = 0; i < 10; i++) step(1'b1, 32'hC000 + i, 1'b0, 1'b0, "peakPush");
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "peakPop");
        step(1'b1, 32'hCCCC, 1'b0, 1'b1, "clear");
        step(1'b0, 32'h0, 1'b0, 1'b0, "cleared");

        // Asynchronous reset between edges at level 5.
        for (int i = 0; i < 5; i++) step(1'b1, 32'hD000 + i, 1'b0, 1'b0, "prePush");
        step(1'b0, 32'h0, 1'b0, 1'b0, "level5");
        @(posedge clock);
        #1 idle_inputs();
        #1 reset = 1'b1;
        #1 check_reset_outputs("asyncReset");
        reset = 1'b0;
        mq.delete();
        popQ.delete();
        mpeak = 0;
        step(1'b1, 32'hE123, 1'b0, 1'b0, "postResetPush");
        step(1'b1, 32'hE124, 1'b1, 1'b0, "postResetPop");
        step(1'b0, 32'h0, 1'b1, 1'b0, "postResetPop2");
        step(1'b0, 32'h0, 1'b0, 1'b0, "postResetIdle");

        // Randomized traffic against the model, with rare clears.
        for (int i = 0; i < 400; i++) begin
            logic pv;
            logic pr;
            logic clr;
            pv  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
            pr  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
            clr = ($urandom_range(0, 99) == 0);
            step(pv, $urandom, pr, clr, "random");
        end
        @(posedge clock);
        #1 idle_inputs();
        @(negedge clock);
        #1;
        check("scoreboardEmpty", 32'(lvlQ.size() + popQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
